// File: rtl/ysyx_22040237_mem_arb.sv
// Shares one memory port between IFU and LSU (LSU has fixed priority), one transaction in flight.
// Request seen on mem_* one cycle after the handshake; response returned one cycle after mem_resp_valid_i.
module ysyx_22040237_mem_arb #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid_i,
    output logic                ifu_req_ready_o,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_resp_valid_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    input  logic                lsu_req_valid_i,
    output logic                lsu_req_ready_o,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic                lsu_wen_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wmask_i,
    output logic                lsu_resp_valid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_wen_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_resp_valid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                err_o
);
    localparam int MW = DATA_W / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              owner_lsu_q, owner_lsu_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MW-1:0]     wmask_q, wmask_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;

    always_comb begin
        state_d     = state_q;
        owner_lsu_d = owner_lsu_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        cnt_d       = cnt_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_req_valid_i) begin
                    owner_lsu_d = 1'b1;
                    addr_d      = lsu_addr_i;
                    wen_d       = lsu_wen_i;
                    wdata_d     = lsu_wdata_i;
                    wmask_d     = lsu_wmask_i;
                    state_d     = S_REQ;
                end else if (ifu_req_valid_i) begin
                    // Fetches are always reads; clear the write payload so nothing stale leaks out.
                    owner_lsu_d = 1'b0;
                    addr_d      = ifu_addr_i;
                    wen_d       = 1'b0;
                    wdata_d     = '0;
                    wmask_d     = '0;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid_i) begin
                    if (owner_lsu_q) lsu_rdata_d = mem_rdata_i;
                    else             ifu_rdata_d = mem_rdata_i;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_lsu_q <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cnt_q       <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_lsu_q <= owner_lsu_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            cnt_q       <= cnt_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign lsu_req_ready_o  = (state_q == S_IDLE);
    assign ifu_req_ready_o  = (state_q == S_IDLE) && !lsu_req_valid_i;
    assign mem_req_valid_o  = (state_q == S_REQ);
    assign mem_addr_o       = mem_req_valid_o ? addr_q  : '0;
    assign mem_wen_o        = mem_req_valid_o ? wen_q   : 1'b0;
    assign mem_wdata_o      = mem_req_valid_o ? wdata_q : '0;
    assign mem_wmask_o      = mem_req_valid_o ? wmask_q : '0;
    assign ifu_resp_valid_o = (state_q == S_RESP) && !owner_lsu_q;
    assign lsu_resp_valid_o = (state_q == S_RESP) &&  owner_lsu_q;
    assign ifu_rdata_o      = ifu_rdata_q;
    assign lsu_rdata_o      = lsu_rdata_q;
    assign err_o            = (state_q == S_ERR);

endmodule

// File: tb/tb_ysyx_22040237_mem_arb.sv
// Bench for ysyx_22040237_mem_arb: directed table, randomized transactions, watchdog and reset corners.
module tb_ysyx_22040237_mem_arb;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid_i, ifu_req_ready_o, ifu_resp_valid_o;
    logic [63:0] ifu_addr_i, ifu_rdata_o;
    logic        lsu_req_valid_i, lsu_req_ready_o, lsu_wen_i, lsu_resp_valid_o;
    logic [63:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic [7:0]  lsu_wmask_i, mem_wmask_o;
    logic        mem_req_valid_o, mem_req_ready_i, mem_wen_o, mem_resp_valid_i, err_o;
    logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22040237_mem_arb #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o), .ifu_addr_i(ifu_addr_i),
        .ifu_resp_valid_o(ifu_resp_valid_o), .ifu_rdata_o(ifu_rdata_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o), .lsu_addr_i(lsu_addr_i),
        .lsu_wen_i(lsu_wen_i), .lsu_wdata_i(lsu_wdata_i), .lsu_wmask_i(lsu_wmask_i),
        .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
        .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [63:0] ifu_addr;
        logic [63:0] lsu_addr;
        logic        lsu_wen;
        logic [63:0] lsu_wdata;
        logic [7:0]  lsu_wmask;
        int          acc_dly;
        int          rsp_dly;
        logic [63:0] rdata;
        logic        exp_lsu;
        logic [63:0] exp_addr;
        logic        exp_wen;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wmask;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: LSU wins whenever valid; a fetch is a read with empty write payload.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        r.exp_lsu = v.lsu_v;
        if (v.lsu_v) begin
            r.exp_addr  = v.lsu_addr;
            r.exp_wen   = v.lsu_wen;
            r.exp_wdata = v.lsu_wdata;
            r.exp_wmask = v.lsu_wmask;
        end else begin
            r.exp_addr  = v.ifu_addr;
            r.exp_wen   = 1'b0;
            r.exp_wdata = 64'h0;
            r.exp_wmask = 8'h0;
        end
        return r;
    endfunction

    task automatic drive(input vec_t v);
        ifu_req_valid_i = v.ifu_v;
        ifu_addr_i      = v.ifu_addr;
        lsu_req_valid_i = v.lsu_v;
        lsu_addr_i      = v.lsu_addr;
        lsu_wen_i       = v.lsu_wen;
        lsu_wdata_i     = v.lsu_wdata;
        lsu_wmask_i     = v.lsu_wmask;
    endtask

    // Entered just after the edge that starts an IDLE cycle with requests already driven.
    task automatic do_txn(input vec_t v);
        @(negedge clk);
        chk("idle_lsu_rdy", lsu_req_ready_o, 1'b1);
        chk("idle_ifu_rdy", ifu_req_ready_o, !v.lsu_v);
        chk("idle_resp_ifu", ifu_resp_valid_o, 1'b0);
        chk("idle_resp_lsu", lsu_resp_valid_o, 1'b0);
        chk("idle_mem_vld", mem_req_valid_o, 1'b0);
        @(posedge clk); #1;
        if (v.exp_lsu) begin
            lsu_req_valid_i = 1'b0;
            lsu_addr_i      = {$urandom, $urandom};
            lsu_wdata_i     = {$urandom, $urandom};
            lsu_wmask_i     = 8'($urandom);
            lsu_wen_i       = ~v.lsu_wen;
        end else begin
            ifu_req_valid_i = 1'b0;
            ifu_addr_i      = {$urandom, $urandom};
        end
        for (int k = 0; k <= v.acc_dly; k++) begin
            mem_req_ready_i = (k == v.acc_dly);
            @(negedge clk);
            chk("req_vld", mem_req_valid_o, 1'b1);
            chk("req_addr", mem_addr_o, v.exp_addr);
            chk("req_wen", mem_wen_o, v.exp_wen);
            chk("req_wdata", mem_wdata_o, v.exp_wdata);
            chk("req_wmask", mem_wmask_o, v.exp_wmask);
            chk("req_lsu_rdy", lsu_req_ready_o, 1'b0);
            chk("req_ifu_rdy", ifu_req_ready_o, 1'b0);
            @(posedge clk); #1;
        end
        mem_req_ready_i = 1'b0;
        for (int k = 1; k <= v.rsp_dly; k++) begin
            mem_resp_valid_i = (k == v.rsp_dly);
            mem_rdata_i      = (k == v.rsp_dly) ? v.rdata : {$urandom, $urandom};
            @(negedge clk);
            chk("wait_mem_vld", mem_req_valid_o, 1'b0);
            chk("wait_mem_addr", mem_addr_o, 64'h0);
            chk("wait_err", err_o, 1'b0);
            chk("wait_resp_ifu", ifu_resp_valid_o, 1'b0);
            chk("wait_resp_lsu", lsu_resp_valid_o, 1'b0);
            @(posedge clk); #1;
        end
        mem_resp_valid_i = 1'b0;
        mem_rdata_i      = {$urandom, $urandom};
        @(negedge clk);
        chk("resp_ifu_vld", ifu_resp_valid_o, !v.exp_lsu);
        chk("resp_lsu_vld", lsu_resp_valid_o, v.exp_lsu);
        chk("resp_rdata", v.exp_lsu ? lsu_rdata_o : ifu_rdata_o, v.rdata);
        chk("resp_lsu_rdy", lsu_req_ready_o, 1'b0);
        chk("resp_err", err_o, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic reset_seq();
        rst = 1'b1;
        lsu_req_valid_i = 1'b0; ifu_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_err", err_o, 1'b0);
        chk("rst_mem_vld", mem_req_valid_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 64'h0);
        chk("rst_lsu_rdy", lsu_req_ready_o, 1'b1);
        chk("rst_ifu_rdy_free", ifu_req_ready_o, 1'b1);
        chk("rst_resp", {ifu_resp_valid_o, lsu_resp_valid_o}, 2'b00);
        chk("rst_ifu_rdata", ifu_rdata_o, 64'h0);
        chk("rst_lsu_rdata", lsu_rdata_o, 64'h0);
        lsu_req_valid_i = 1'b1;
        #1;
        chk("rst_ifu_rdy_blocked", ifu_req_ready_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        lsu_req_valid_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

    vec_t tbl[5];
    vec_t v;
    logic hold_ifu;
    logic [63:0] hold_addr;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 64'h8000_0000, 64'h1234, 1'b1, 64'h5555, 8'hFF, 0, 1,
                   64'h0000_0013_0000_0093, 1'b0, 64'h8000_0000, 1'b0, 64'h0, 8'h00};
        tbl[1] = '{1'b1, 1'b1, 64'h8000_0004, 64'h8000_1000, 1'b0, 64'h0, 8'h00, 1, 2,
                   64'hAAAA_0000_1111_2222, 1'b1, 64'h8000_1000, 1'b0, 64'h0, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 64'h8000_0004, 64'h0, 1'b0, 64'h0, 8'h00, 0, 1,
                   64'h0000_0000_0000_0297, 1'b0, 64'h8000_0004, 1'b0, 64'h0, 8'h00};
        tbl[3] = '{1'b0, 1'b1, 64'h0, 64'h8000_2000, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 3, 1,
                   64'h0, 1'b1, 64'h8000_2000, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F};
        tbl[4] = '{1'b0, 1'b1, 64'h0, 64'h8000_3008, 1'b0, 64'h77, 8'h33, 2, TO,
                   64'hFEED_FACE_0BAD_F00D, 1'b1, 64'h8000_3008, 1'b0, 64'h77, 8'h33};

        ifu_addr_i = '0; lsu_addr_i = '0; lsu_wen_i = 1'b0; lsu_wdata_i = '0; lsu_wmask_i = '0;
        mem_rdata_i = '0;
        reset_seq();

        for (int i = 0; i < 5; i++) begin
            drive(tbl[i]);
            do_txn(tbl[i]);
        end

        hold_ifu = 1'b0;
        hold_addr = '0;
        for (int i = 0; i < 40; i++) begin
            v.ifu_v     = hold_ifu ? 1'b1 : 1'($urandom_range(0, 1));
            v.lsu_v     = 1'($urandom_range(0, 1));
            if (!v.ifu_v && !v.lsu_v) v.lsu_v = 1'b1;
            v.ifu_addr  = hold_ifu ? hold_addr : {$urandom, $urandom};
            v.lsu_addr  = {$urandom, $urandom};
            v.lsu_wen   = 1'($urandom_range(0, 1));
            v.lsu_wdata = {$urandom, $urandom};
            v.lsu_wmask = 8'($urandom);
            v.acc_dly   = $urandom_range(0, 3);
            v.rsp_dly   = $urandom_range(1, TO);
            v.rdata     = {$urandom, $urandom};
            v = predict(v);
            drive(v);
            do_txn(v);
            hold_ifu  = v.ifu_v && v.lsu_v;
            hold_addr = v.ifu_addr;
        end
        if (hold_ifu) begin
            v.lsu_v = 1'b0;
            v.acc_dly = 0; v.rsp_dly = 1; v.rdata = 64'h1357_9BDF_2468_ACE0;
            v = predict(v);
            drive(v);
            do_txn(v);
        end

        // Reset while waiting for the memory: the pending response must never appear.
        ifu_req_valid_i = 1'b1; ifu_addr_i = 64'h8000_0100;
        @(posedge clk); #1;
        ifu_req_valid_i = 1'b0; mem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        mem_req_ready_i = 1'b0;
        @(negedge clk);
        chk("rw_in_wait", mem_req_valid_o, 1'b0);
        rst = 1'b1; mem_resp_valid_i = 1'b1; mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_no_resp", {ifu_resp_valid_o, lsu_resp_valid_o}, 2'b00);
        chk("rw_idle_rdy", lsu_req_ready_o, 1'b1);
        rst = 1'b0; mem_resp_valid_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rw_no_resp_after", {ifu_resp_valid_o, lsu_resp_valid_o}, 2'b00);
        @(posedge clk); #1;
        v = '{1'b1, 1'b0, 64'h8000_0200, 64'h0, 1'b0, 64'h0, 8'h00, 1, 2,
              64'h0000_0000_0000_0073, 1'b0, 64'h8000_0200, 1'b0, 64'h0, 8'h00};
        drive(v);
        do_txn(v);

        // Watchdog: memory accepts then stays silent for TO wait cycles.
        lsu_req_valid_i = 1'b1; lsu_wen_i = 1'b0; lsu_addr_i = 64'h8000_3000;
        @(posedge clk); #1;
        lsu_req_valid_i = 1'b0; mem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        mem_req_ready_i = 1'b0;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            chk("wd_no_err_yet", err_o, 1'b0);
            @(posedge clk); #1;
        end
        lsu_req_valid_i = 1'b1; ifu_req_valid_i = 1'b1;
        mem_req_ready_i = 1'b1; mem_resp_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wd_err", err_o, 1'b1);
            chk("wd_lsu_rdy", lsu_req_ready_o, 1'b0);
            chk("wd_ifu_rdy", ifu_req_ready_o, 1'b0);
            chk("wd_mem_vld", mem_req_valid_o, 1'b0);
            chk("wd_resp", {ifu_resp_valid_o, lsu_resp_valid_o}, 2'b00);
            @(posedge clk); #1;
        end
        reset_seq();
        v = '{1'b0, 1'b1, 64'h0, 64'h8000_4000, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 1,
              64'h0, 1'b1, 64'h8000_4000, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0};
        drive(v);
        do_txn(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22040237_mem_arb.md
# ysyx_22040237_mem_arb

Shares one memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the ysyx_22040237 multi-cycle core. It accepts one request at a time over valid/ready, gives the LSU fixed priority, and issues the request to the memory port. It then waits for the memory response and returns the read data to the requester for one cycle. A response watchdog latches a sticky error, which the simulation environment uses to stop the run.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width; mask width is DATA_W/8
- TIMEOUT, 255, max cycles in WAIT before error; legal range 1..1023
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- ifu_req_valid_i  in  1  fetch request valid (always a read)
- ifu_req_ready_o  out  1  fetch request accepted
- ifu_addr_i  in  ADDR_W  fetch address
- ifu_resp_valid_o  out  1  fetch data valid, one-cycle pulse
- ifu_rdata_o  out  DATA_W  fetch read data
- lsu_req_valid_i  in  1  load/store request valid
- lsu_req_ready_o  out  1  load/store request accepted
- lsu_addr_i  in  ADDR_W  load/store address
- lsu_wen_i  in  1  1 = store, 0 = load
- lsu_wdata_i  in  DATA_W  store data
- lsu_wmask_i  in  DATA_W/8  store byte mask
- lsu_resp_valid_o  out  1  load done / store acknowledged, one-cycle pulse
- lsu_rdata_o  out  DATA_W  load read data (don't-care for stores)
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_addr_o  out  ADDR_W  memory address
- mem_wen_o  out  1  memory write enable
- mem_wdata_o  out  DATA_W  memory write data
- mem_wmask_o  out  DATA_W/8  memory byte mask
- mem_resp_valid_i  in  1  memory response valid (reads and writes)
- mem_rdata_i  in  DATA_W  memory read data
- err_o  out  1  sticky watchdog error

## Operation
- **States:** IDLE, REQ, WAIT, RESP, ERR. Single outstanding transaction.
- **IDLE:**
  - lsu_req_ready_o = 1.
  - ifu_req_ready_o = !lsu_req_valid_i.
  - The LSU wins when both requesters are valid.
  - On a handshake (valid & ready):
    - latch owner, addr, wen, wdata and wmask into registers;
    - an IFU request latches wen=0, wdata=0, wmask=0;
    - go to REQ.
- **REQ:**
  - mem_req_valid_o = 1; mem_* outputs are driven from the latched registers.
  - On mem_req_ready_i, go to WAIT and clear the watchdog counter.
- **WAIT:**
  - The counter increments every cycle.
  - On mem_resp_valid_i: latch mem_rdata_i and go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1: go to ERR.
  - If mem_resp_valid_i and the timeout coincide, the response wins.
- **RESP:**
  - The owner's resp_valid_o = 1 for exactly this cycle; the other requester's resp_valid_o stays 0.
  - The owner's rdata_o carries the latched data.
  - Next state is IDLE.
- **ERR:**
  - err_o = 1; both ready outputs = 0; mem_req_valid_o = 0.
  - Stays in ERR until rst.
- **Ignored inputs:**
  - mem_resp_valid_i is ignored outside WAIT.
  - mem_req_ready_i is ignored outside REQ.
- **Output hygiene:**
  - mem_addr_o, mem_wen_o, mem_wdata_o and mem_wmask_o are 0 when mem_req_valid_o = 0.
  - rdata outputs hold their last latched value; they are sampled only with resp_valid_o.
- **Requester rules:**
  - A requester keeps valid and its payload stable until ready.
  - A requester never drops valid before the handshake.
- The watchdog counter is ceil(log2(TIMEOUT+1)) bits wide and does not wrap.

## Timing
- **Reset values:**
  - state IDLE; counter 0; err_o 0.
  - mem_req_valid_o 0; both resp_valid_o 0.
  - All latched registers and rdata outputs 0.
  - lsu_req_ready_o 1; ifu_req_ready_o = !lsu_req_valid_i.
- Ready outputs are combinational from state and lsu_req_valid_i. All other outputs are registered or derived from state only.
- **Best-case latency:**
  - handshake in cycle N;
  - mem_req_valid_o in N+1, memory accepts in N+1;
  - memory responds in N+2;
  - resp_valid_o in N+3;
  - next handshake possible in N+4.
- Throughput is at most one transaction per 4 cycles.
- The memory must not assert mem_resp_valid_i in the same cycle it accepts a request.
- **Reset mid-transaction:** the transaction is discarded with no resp_valid_o; state returns to IDLE on the next edge. The memory model is reset together with the arbiter.
- A new request presented during RESP is not accepted until IDLE.

## Test plan
- **Reset:** hold rst 2 cycles → err_o=0, mem_req_valid_o=0, lsu_req_ready_o=1, state IDLE.
- **IFU read:** IFU read of 0x8000_0000, memory returns 0x0000_0013_0000_0093 one cycle after accept → mem_req_valid_o at N+1 with addr 0x8000_0000, wen 0; ifu_resp_valid_o pulses exactly one cycle at N+3 with that data; lsu_resp_valid_o stays 0.
- **Simultaneous requests:** IFU valid (0x8000_0004) and LSU load (0x8000_1000) in the same cycle → LSU granted first, with ifu_req_ready_o=0 that cycle. The IFU is served on the next IDLE, and its address 0x8000_0004 appears on mem_addr_o in the second transaction.
- **LSU store with backpressure:** LSU store addr 0x8000_2000, wdata 0xDEAD_BEEF_CAFE_F00D, wmask 0x0F; memory holds mem_req_ready_i=0 for 3 cycles → mem_* outputs stable for 4 cycles; lsu_resp_valid_o one cycle after mem_resp_valid_i.
- **Watchdog:** TIMEOUT=4, memory never responds → ERR entered 4 cycles after accept. err_o stays 1, both ready outputs 0, and further requests are ignored until rst. A response at exactly cycle 4 instead yields a normal RESP with err_o=0.
- **Reset in WAIT:** assert rst in WAIT → no resp_valid_o on either port; the next IFU request completes normally.
